// File: rtl/shadow_regfile_if.sv
// Bus bundle between decode/writeback and the shadow register file.
//   master : drives ucode_flag, commit, we, waddr, wdata, raddr; receives rdata, dirty, in_ucode
//   slave  : the register file side
interface shadow_regfile_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned NRD    = 3
);
    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic                    ucode_flag;
    logic                    commit;
    logic                    we;
    logic [ADDR_W-1:0]       waddr;
    logic [DATA_W-1:0]       wdata;
    logic [NRD*ADDR_W-1:0]   raddr;
    logic [NRD*DATA_W-1:0]   rdata;
    logic [NREGS-1:0]        dirty;
    logic                    in_ucode;

    modport master (
        output ucode_flag, commit, we, waddr, wdata, raddr,
        input  rdata, dirty, in_ucode
    );

    modport slave (
        input  ucode_flag, commit, we, waddr, wdata, raddr,
        output rdata, dirty, in_ucode
    );
endinterface

// File: rtl/shadow_regfile.sv
// Architectural + shadow register file for microcode sequences.
// Entry into microcode snapshots arch into shadow on the detecting edge;
// exit optionally commits shadow back into arch. Reads are combinational.
//   clk, rst : clock, synchronous active-high reset
//   bus      : shadow_regfile_if slave (flag/commit/write/read ports, dirty mask, in_ucode)
module shadow_regfile #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NRD      = 3,
    parameter bit          BYPASS   = 1'b0,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    shadow_regfile_if.slave    bus
);
    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]     arch_q   [NREGS];
    logic [DATA_W-1:0]     arch_d   [NREGS];
    logic [DATA_W-1:0]     shadow_q [NREGS];
    logic [DATA_W-1:0]     shadow_d [NREGS];
    logic [NREGS-1:0]      dirty_q;
    logic [NREGS-1:0]      dirty_d;
    logic                  flag_q;
    logic                  flag_d;

    logic                  entry_c;
    logic                  exit_c;
    logic                  wr_ok_c;
    logic [NRD*DATA_W-1:0] rdata_c;
    logic [ADDR_W-1:0]     ra;
    logic [DATA_W-1:0]     rd;

    // Transition detection uses the live flag against its registered copy.
    assign entry_c = bus.ucode_flag  & ~flag_q;
    assign exit_c  = ~bus.ucode_flag &  flag_q;
    assign wr_ok_c = bus.we & ~(ZERO_REG && (bus.waddr == '0));

    // Next-state: bulk copy first, then the same-edge write overrides its index.
    always_comb begin
        arch_d   = arch_q;
        shadow_d = shadow_q;
        dirty_d  = dirty_q;
        flag_d   = bus.ucode_flag;

        if (entry_c) begin
            for (int i = 0; i < NREGS; i++) begin
                shadow_d[i] = arch_q[i];
            end
            dirty_d = '0;
        end

        if (exit_c) begin
            if (bus.commit) begin
                for (int i = 0; i < NREGS; i++) begin
                    arch_d[i] = shadow_q[i];
                end
            end
            dirty_d = '0;
        end

        if (wr_ok_c) begin
            if (bus.ucode_flag) begin
                shadow_d[bus.waddr] = bus.wdata;
                dirty_d[bus.waddr]  = 1'b1;
            end else begin
                arch_d[bus.waddr] = bus.wdata;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q  <= 1'b0;
            dirty_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                arch_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            flag_q  <= flag_d;
            dirty_q <= dirty_d;
            for (int i = 0; i < NREGS; i++) begin
                arch_q[i]   <= arch_d[i];
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    // Combinational read ports; zero register beats bypass, reset forces zero.
    always_comb begin
        rdata_c = '0;
        ra      = '0;
        rd      = '0;
        for (int k = 0; k < NRD; k++) begin
            ra = bus.raddr[k*ADDR_W +: ADDR_W];
            rd = bus.ucode_flag ? shadow_q[ra] : arch_q[ra];
            if (BYPASS && bus.we && (bus.waddr == ra)) begin
                rd = bus.wdata;
            end
            if (ZERO_REG && (ra == '0)) begin
                rd = '0;
            end
            if (rst) begin
                rd = '0;
            end
            rdata_c[k*DATA_W +: DATA_W] = rd;
        end
    end

    assign bus.rdata    = rdata_c;
    assign bus.dirty    = dirty_q;
    assign bus.in_ucode = flag_q;

endmodule

// File: tb/tb_shadow_regfile.sv
// Self-checking bench: two instances (plain, and bypass + zero register)
// driven with identical stimulus and compared against an array model.
module tb_shadow_regfile;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shadow_regfile_if #(.DATA_W(32), .ADDR_W(4), .NRD(3)) if0 ();
    shadow_regfile_if #(.DATA_W(32), .ADDR_W(4), .NRD(3)) if1 ();

    shadow_regfile #(.DATA_W(32), .ADDR_W(4), .NRD(3), .BYPASS(1'b0), .ZERO_REG(1'b0))
        u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    shadow_regfile #(.DATA_W(32), .ADDR_W(4), .NRD(3), .BYPASS(1'b1), .ZERO_REG(1'b1))
        u1 (.clk(clk), .rst(rst), .bus(if1.slave));

    int n_vec = 0;
    int n_err = 0;

    // current inputs
    logic        c_rst, c_flag, c_commit, c_we;
    logic [3:0]  c_waddr;
    logic [31:0] c_wdata;
    logic [11:0] c_raddr;

    // reference state: index 0 = plain config, 1 = bypass + zero register
    logic [31:0] m_arch   [2][16];
    logic [31:0] m_shadow [2][16];
    logic [15:0] m_dirty  [2];
    logic        m_flag;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input int c, input logic [3:0] a);
        if (c_rst) return 32'h0;
        if (c == 1 && a == 4'd0) return 32'h0;
        if (c == 1 && c_we && c_waddr == a) return c_wdata;
        return c_flag ? m_shadow[c][a] : m_arch[c][a];
    endfunction

    task automatic model_edge();
        bit entry, leave;
        entry = c_flag && !m_flag;
        leave = !c_flag && m_flag;
        for (int c = 0; c < 2; c++) begin
            if (c_rst) begin
                for (int i = 0; i < 16; i++) begin
                    m_arch[c][i]   = 32'h0;
                    m_shadow[c][i] = 32'h0;
                end
                m_dirty[c] = 16'h0;
            end else begin
                if (entry) begin
                    for (int i = 0; i < 16; i++) m_shadow[c][i] = m_arch[c][i];
                    m_dirty[c] = 16'h0;
                end
                if (leave) begin
                    if (c_commit)
                        for (int i = 0; i < 16; i++) m_arch[c][i] = m_shadow[c][i];
                    m_dirty[c] = 16'h0;
                end
                if (c_we && !(c == 1 && c_waddr == 4'd0)) begin
                    if (c_flag) begin
                        m_shadow[c][c_waddr] = c_wdata;
                        m_dirty[c][c_waddr]  = 1'b1;
                    end else begin
                        m_arch[c][c_waddr] = c_wdata;
                    end
                end
            end
        end
        m_flag = c_rst ? 1'b0 : c_flag;
    endtask

    task automatic check_all();
        logic [3:0] a;
        for (int k = 0; k < 3; k++) begin
            a = c_raddr[k*4 +: 4];
            chk($sformatf("u0_rd%0d_a%0d", k, a), 64'(if0.rdata[k*32 +: 32]), 64'(exp_rd(0, a)));
            chk($sformatf("u1_rd%0d_a%0d", k, a), 64'(if1.rdata[k*32 +: 32]), 64'(exp_rd(1, a)));
        end
        chk("u0_dirty", 64'(if0.dirty), 64'(m_dirty[0]));
        chk("u1_dirty", 64'(if1.dirty), 64'(m_dirty[1]));
        chk("u0_in_ucode", 64'(if0.in_ucode), 64'(m_flag));
        chk("u1_in_ucode", 64'(if1.in_ucode), 64'(m_flag));
    endtask

    // drive one cycle of inputs and check at the falling edge
    task automatic apply(input logic r, input logic f, input logic cm, input logic w,
                         input logic [3:0] wa, input logic [31:0] wd, input logic [11:0] ra);
        c_rst = r; c_flag = f; c_commit = cm; c_we = w;
        c_waddr = wa; c_wdata = wd; c_raddr = ra;
        rst = r;
        if0.ucode_flag = f; if0.commit = cm; if0.we = w;
        if0.waddr = wa; if0.wdata = wd; if0.raddr = ra;
        if1.ucode_flag = f; if1.commit = cm; if1.we = w;
        if1.waddr = wa; if1.wdata = wd; if1.raddr = ra;
        @(negedge clk);
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 16; i++) begin
                m_arch[c][i] = 32'h0; m_shadow[c][i] = 32'h0;
            end
            m_dirty[c] = 16'h0;
        end
        m_flag = 1'b0;
        c_rst = 1'b1; c_flag = 1'b0; c_commit = 1'b0; c_we = 1'b0;
        c_waddr = 4'd0; c_wdata = 32'h0; c_raddr = 12'h0;
        rst = 1'b1;
        if0.ucode_flag = 1'b0; if0.commit = 1'b0; if0.we = 1'b0;
        if0.waddr = '0; if0.wdata = '0; if0.raddr = '0;
        if1.ucode_flag = 1'b0; if1.commit = 1'b0; if1.we = 1'b0;
        if1.waddr = '0; if1.wdata = '0; if1.raddr = '0;
        @(posedge clk); model_edge(); #1;

        // reset state
        apply(1, 0, 0, 0, 4'd0, 32'h0, 12'h521); tick();
        chk("rst_u0_rd0", 64'(if0.rdata[31:0]), 64'h0);

        // arch r5 then snapshot
        apply(0, 0, 0, 1, 4'd5, 32'hDEADBEEF, 12'h555); tick();
        apply(0, 1, 0, 0, 4'd0, 32'h0, 12'h555); tick();
        apply(0, 1, 0, 0, 4'd0, 32'h0, 12'h555);
        chk("tp_snap_r5", 64'(if0.rdata[31:0]), 64'hDEADBEEF);
        chk("tp_snap_dirty", 64'(if0.dirty), 64'h0);
        chk("tp_snap_in_ucode", 64'(if0.in_ucode), 64'h1);
        tick();
        apply(0, 0, 0, 0, 4'd0, 32'h0, 12'h000); tick();

        // entry-edge write beats snapshot
        apply(0, 0, 0, 1, 4'd3, 32'h22, 12'h333); tick();
        apply(0, 1, 0, 1, 4'd3, 32'h11, 12'h333); tick();
        apply(0, 1, 0, 0, 4'd0, 32'h0, 12'h333);
        chk("tp_entry_wr_r3", 64'(if0.rdata[63:32]), 64'h11);
        chk("tp_entry_dirty", 64'(if0.dirty), 64'h0008);
        tick();
        apply(0, 0, 0, 0, 4'd0, 32'h0, 12'h333); tick();
        apply(0, 0, 0, 0, 4'd0, 32'h0, 12'h333);
        chk("tp_arch_r3", 64'(if0.rdata[95:64]), 64'h22);
        tick();

        // commit and abandon
        apply(0, 1, 0, 0, 4'd0, 32'h0, 12'h777); tick();
        apply(0, 1, 0, 1, 4'd7, 32'hA5, 12'h777); tick();
        apply(0, 0, 1, 0, 4'd0, 32'h0, 12'h777); tick();
        apply(0, 0, 0, 0, 4'd0, 32'h0, 12'h777);
        chk("tp_commit_r7", 64'(if0.rdata[31:0]), 64'hA5);
        chk("tp_commit_dirty", 64'(if0.dirty), 64'h0);
        tick();
        apply(0, 1, 1, 0, 4'd0, 32'h0, 12'h777); tick();
        apply(0, 1, 1, 1, 4'd7, 32'h5A, 12'h777); tick();
        apply(0, 0, 0, 0, 4'd0, 32'h0, 12'h777); tick();
        apply(0, 0, 1, 0, 4'd0, 32'h0, 12'h777);
        chk("tp_abandon_r7", 64'(if0.rdata[31:0]), 64'hA5);
        tick();

        // exit-edge arch write beats commit
        apply(0, 1, 0, 0, 4'd0, 32'h0, 12'h777); tick();
        apply(0, 1, 0, 1, 4'd7, 32'hA5, 12'h777); tick();
        apply(0, 0, 1, 1, 4'd7, 32'h99, 12'h777); tick();
        apply(0, 0, 0, 0, 4'd0, 32'h0, 12'h777);
        chk("tp_exit_wr_r7", 64'(if0.rdata[31:0]), 64'h99);
        tick();

        // bypass and zero register (u1)
        apply(0, 0, 0, 1, 4'd2, 32'h1234, 12'h222);
        chk("tp_byp_all", 64'(if1.rdata), 64'(96'h00001234_00001234_00001234));
        tick();
        apply(0, 0, 0, 1, 4'd0, 32'hFF, 12'h000);
        chk("tp_zero_byp", 64'(if1.rdata[31:0]), 64'h0);
        tick();
        apply(0, 1, 0, 1, 4'd0, 32'hFF, 12'h000); tick();
        apply(0, 1, 0, 0, 4'd0, 32'h0, 12'h000);
        chk("tp_zero_dirty_u1", 64'(if1.dirty[0]), 64'h0);
        chk("tp_zero_dirty_u0", 64'(if0.dirty[0]), 64'h1);
        tick();

        // reset mid-ucode with r4 dirty, flag held high
        apply(0, 1, 0, 1, 4'd4, 32'h44, 12'h444); tick();
        apply(1, 1, 0, 0, 4'd0, 32'h0, 12'h444); tick();
        apply(1, 1, 0, 0, 4'd0, 32'h0, 12'h444);
        chk("tp_rst_rd", 64'(if0.rdata), 64'h0);
        chk("tp_rst_dirty", 64'(if0.dirty), 64'h0);
        chk("tp_rst_in_ucode", 64'(if0.in_ucode), 64'h0);
        tick();
        apply(0, 1, 0, 0, 4'd0, 32'h0, 12'h754); tick();
        apply(0, 1, 0, 0, 4'd0, 32'h0, 12'h754);
        chk("tp_post_rst_r4", 64'(if0.rdata[31:0]), 64'h0);
        chk("tp_post_rst_in_ucode", 64'(if0.in_ucode), 64'h1);
        tick();

        // randomized traffic
        begin
            logic f;
            f = 1'b1;
            for (int n = 0; n < 600; n++) begin
                if ($urandom_range(0, 3) == 0) f = ~f;
                apply(($urandom_range(0, 59) == 0), f, 1'($urandom), ($urandom_range(0, 2) != 0),
                      4'($urandom), $urandom, 12'($urandom));
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/shadow_regfile.md
# shadow_regfile

Parametrised successor of the single-shadow microcode register file, sitting between decode/writeback and the execute stage of the SCC core. It holds an architectural bank and a shadow bank for microcode sequences, with a configurable number of combinational read ports, optional write-to-read bypass, and an optional hardwired zero register. Entering microcode snapshots architectural state into the shadow bank on the same edge, and exiting can commit shadow results back. A per-register dirty mask tracks which shadow registers were written.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 4, address width; NREGS = 2**ADDR_W registers per bank
- NRD, 3, number of read ports
- BYPASS, 0, 1 = a read of the register being written this cycle, in the active bank, returns wdata
- ZERO_REG, 0, 1 = register 0 reads as 0 in both banks and ignores writes

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- ucode_flag  input  1  1 = microcode mode; selects the shadow bank for reads and writes
- commit  input  1  sampled only on the exit edge; 1 = copy shadow to arch
- we  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  DATA_W  write data
- raddr  input  NRD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rdata  output  NRD*DATA_W  read data; port k at bits [k*DATA_W +: DATA_W]
- dirty  output  NREGS  bit i = shadow[i] written since the last entry
- in_ucode  output  1  registered copy of ucode_flag (flag_q)

## Operation
- Active bank = shadow when ucode_flag=1, else arch. It is the current input, not flag_q.
- Reads are combinational: rdata[k] = active_bank[raddr[k]].
  - BYPASS=1 with we=1 and waddr==raddr[k]: rdata[k] = wdata.
  - ZERO_REG=1 and raddr[k]==0: rdata[k] = 0. This overrides bypass.
- Write: we=1 writes wdata to active_bank[waddr]. Ignored when ZERO_REG=1 and waddr==0.
- Entry edge (ucode_flag=1, flag_q=0):
  - shadow[i] <= arch[i] for all i.
  - A same-edge write to shadow[waddr] wins over the copy for that index.
  - dirty is cleared, then bit waddr is set if the write occurred.
- In ucode (ucode_flag=1, flag_q=1): a write sets dirty[waddr]. Arch is never written.
- Exit edge (ucode_flag=0, flag_q=1):
  - commit=1: arch[i] <= shadow[i] for all i. A same-edge arch write to waddr wins for that index.
  - commit=0: shadow contents are abandoned and arch is unchanged except for a same-edge write.
  - dirty <= 0 in both cases.
- Register 0 is never dirty when ZERO_REG=1.
- flag_q <= ucode_flag every cycle; in_ucode = flag_q.

## Timing
- Reset: both banks all zero; flag_q=0; dirty=0; in_ucode=0.
  - rdata is 0 for every address during and after reset, until a write.
- Write latency: the value is readable the cycle after the write edge. With BYPASS=1 it is also readable in the write cycle.
- Snapshot and commit complete on the single detecting edge. No busy or stall cycles.
- Back-to-back transitions:
  - Exit then re-entry one cycle later performs a fresh snapshot, taken from the just-committed arch if commit=1.
  - A one-cycle ucode pulse (1 then 0) performs entry then exit on consecutive edges.
- Reset mid-ucode: everything clears and flag_q=0. If ucode_flag stays 1, the first post-reset edge is an entry edge that snapshots zeros.
- commit is ignored on every edge except an exit edge.

## Test plan
- Reset, then write arch r5=0xDEADBEEF, raise ucode_flag -> next cycle shadow r5 reads 0xDEADBEEF, dirty=0, in_ucode=1.
- Entry edge with we=1, waddr=3, wdata=0x11 while arch r3=0x22 -> shadow r3=0x11, dirty=0x0008, arch r3 still 0x22.
- In ucode write r7=0xA5, exit with commit=1 -> arch r7=0xA5, dirty=0. Repeat with commit=0 -> arch r7 keeps its prior value.
- Exit edge with commit=1, we=1, waddr=7, wdata=0x99 while shadow r7=0xA5 -> arch r7=0x99 (write wins).
- BYPASS=1, ZERO_REG=1, NRD=3: write r2=0x1234 with all raddr=2 -> same-cycle rdata=0x1234 on all ports. Write r0=0xFF -> r0 reads 0, dirty[0]=0.
- Assert rst while in ucode with shadow r4 dirty, keep ucode_flag=1 -> all reads 0, dirty=0, in_ucode=0 during reset. The first post-reset edge re-enters with shadow all zero.
